ultrasound_location_calculator: RTL and testbench

//  Sweeps an array of ultrasound rangefinders one at a time. Each sensor is pinged 3 times and the echo width measured.
//  The median of the 3 passes is kept per sensor; the nearest valid sensor gives the reported rover location.

---
 rtl/ultrasound_location_calculator_pkg.sv | 37 +++
 rtl/ultrasound_location_calculator_median3.sv | 21 ++
 rtl/ultrasound_location_calculator.sv | 203 ++++++++++++++++++++
 tb/tb_ultrasound_location_calculator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ultrasound_location_calculator_pkg.sv
// Shared types and constants for the ultrasound rangefinder sweep controller.
package ultrasound_location_calculator_pkg;

  // Codes are visible on the debug state port, so keep them fixed.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_TRIGGER     = 4'd1,
    ST_WAIT_ECHO   = 4'd2,
    ST_MEASURE     = 4'd3,
    ST_STORE       = 4'd4,
    ST_GAP         = 4'd5,
    ST_POWER_CYCLE = 4'd6,
    ST_MEDIAN      = 4'd7,
    ST_NEXT        = 4'd8,
    ST_COMPARE     = 4'd9,
    ST_DONE        = 4'd10
  } state_e;

  typedef struct packed {
    logic [3:0] angle;
    logic [7:0] distance;
  } location_t;

  localparam logic [7:0]  INVALID_DIST = 8'hFF;
  localparam logic [11:0] NO_LOCATION  = 12'hFFF;
  localparam logic [7:0]  MAX_VALID    = 8'hFE;

  // Echo count to distance: half the count plus a fixed offset, clamped
  // below INVALID_DIST so a real reading never looks like a failed pass.
  function automatic logic [7:0] calc_pass(input logic [7:0] count,
                                           input logic [7:0] offset);
    logic [8:0] sum;
    sum = {1'b0, count >> 1} + {1'b0, offset};
    return (sum > {1'b0, MAX_VALID}) ? MAX_VALID : sum[7:0];
  endfunction

endpackage

// File: rtl/ultrasound_location_calculator_median3.sv
// Combinational median of three 8-bit values; 8'hFF naturally sorts last.
module ultrasound_location_calculator_median3 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] c_i,
  output logic [7:0] y_o
);

  logic [7:0] lo_ab;
  logic [7:0] hi_ab;
  logic [7:0] hi_lim;

  // median = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo_ab  = (a_i < b_i) ? a_i : b_i;
    hi_ab  = (a_i < b_i) ? b_i : a_i;
    hi_lim = (hi_ab < c_i) ? hi_ab : c_i;
    y_o    = (lo_ab > hi_lim) ? lo_ab : hi_lim;
  end

endmodule

// File: rtl/ultrasound_location_calculator.sv
// Sweeps the rangefinder array, three pings per sensor, keeps the median
// per sensor and reports the nearest valid sensor as {angle, distance}.
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | waiting for calculate after reset
// TRIGGER     | trigger line of current sensor high
// WAIT_ECHO   | waiting for echo rise, bounded by the wait timer
// MEASURE     | counting echo-high clocks
// STORE       | convert count to a pass distance
// GAP         | quiet time before next trigger
// POWER_CYCLE | invalid pass: current sensor power dropped
// MEDIAN      | median of the three passes latched
// COMPARE     | update nearest sensor
// NEXT        | advance sensor or finish
// DONE        | result valid, waiting for calculate
module ultrasound_location_calculator
  import ultrasound_location_calculator_pkg::*;
#(
  parameter int NUM_SENSORS     = 10,
  parameter int TRIGGER_CYCLES  = 4,
  parameter int GAP_CYCLES      = 5,
  parameter int MAX_ECHO_CYCLES = 100,
  parameter int MAX_WAIT_CYCLES = 200,
  parameter int POWER_CYCLES    = 6,
  parameter int DIST_OFFSET     = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   calculate,
  input  logic [NUM_SENSORS-1:0] ultrasound_signals,
  output logic                   done,
  output logic [11:0]            rover_location,
  output logic [NUM_SENSORS-1:0] ultrasound_commands,
  output logic [NUM_SENSORS-1:0] ultrasound_power,
  output logic [3:0]             state
);

  localparam logic [7:0] TRIG_LOAD  = 8'(TRIGGER_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] WAIT_LOAD  = 8'(MAX_WAIT_CYCLES - 1);
  localparam logic [7:0] POWER_LOAD = 8'(POWER_CYCLES - 1);
  localparam logic [7:0] ECHO_LAST  = 8'(MAX_ECHO_CYCLES - 1);
  localparam logic [3:0] LAST_SENSOR = 4'(NUM_SENSORS - 1);

  state_e          state_q, state_d;
  logic [3:0]      sensor_q, sensor_d;
  logic [1:0]      pass_q, pass_d;
  logic [7:0]      tmr_q, tmr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0][7:0] pv_q, pv_d;
  logic [7:0]      med_q, med_d;
  logic [7:0]      best_q, best_d;
  logic [3:0]      best_idx_q, best_idx_d;
  location_t       loc_q, loc_d;
  logic [7:0]      med_w;
  logic            echo;

  ultrasound_location_calculator_median3 u_median3 (
    .a_i (pv_q[0]),
    .b_i (pv_q[1]),
    .c_i (pv_q[2]),
    .y_o (med_w)
  );

  assign echo           = ultrasound_signals[sensor_q];
  assign state          = state_q;
  assign done           = (state_q == ST_DONE);
  assign rover_location = loc_q;

  // Trigger and power lines follow the registered state of the selected sensor.
  always_comb begin
    ultrasound_commands = '0;
    ultrasound_power    = '1;
    if (state_q == ST_TRIGGER)     ultrasound_commands[sensor_q] = 1'b1;
    if (state_q == ST_POWER_CYCLE) ultrasound_power[sensor_q]    = 1'b0;
  end

  // Next-state logic; one down-counter tmr serves every timed state.
  always_comb begin
    state_d    = state_q;
    sensor_d   = sensor_q;
    pass_d     = pass_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    pv_d       = pv_q;
    med_d      = med_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    loc_d      = loc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (calculate) begin
          state_d    = ST_TRIGGER;
          sensor_d   = '0;
          pass_d     = '0;
          best_d     = INVALID_DIST;
          best_idx_d = '0;
          tmr_d      = TRIG_LOAD;
        end
      end
      ST_TRIGGER: begin
        if (tmr_q == '0) begin
          state_d = ST_WAIT_ECHO;
          tmr_d   = WAIT_LOAD;
        end else tmr_d = tmr_q - 8'd1;
      end
      ST_WAIT_ECHO: begin
        if (echo) begin
          state_d = ST_MEASURE;
          cnt_d   = 8'd1;
        end else if (tmr_q == '0) begin
          state_d = ST_POWER_CYCLE;
          tmr_d   = POWER_LOAD;
        end else tmr_d = tmr_q - 8'd1;
      end
      ST_MEASURE: begin
        if (!echo) state_d = ST_STORE;
        else if (cnt_q == ECHO_LAST) begin
          state_d = ST_POWER_CYCLE;
          tmr_d   = POWER_LOAD;
        end else cnt_d = cnt_q + 8'd1;
      end
      ST_STORE: begin
        pv_d[pass_q] = calc_pass(cnt_q, 8'(DIST_OFFSET));
        state_d      = ST_GAP;
        tmr_d        = GAP_LOAD;
      end
      ST_POWER_CYCLE: begin
        pv_d[pass_q] = INVALID_DIST;
        if (tmr_q == '0) begin
          state_d = ST_GAP;
          tmr_d   = GAP_LOAD;
        end else tmr_d = tmr_q - 8'd1;
      end
      ST_GAP: begin
        if (tmr_q != '0) tmr_d = tmr_q - 8'd1;
        else if (pass_q < 2'd2) begin
          pass_d  = pass_q + 2'd1;
          state_d = ST_TRIGGER;
          tmr_d   = TRIG_LOAD;
        end else state_d = ST_MEDIAN;
      end
      ST_MEDIAN: begin
        med_d   = med_w;
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        // Strict compare: on a tie the earlier (lower) sensor is kept.
        if (med_q != INVALID_DIST && med_q < best_q) begin
          best_d     = med_q;
          best_idx_d = sensor_q;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (sensor_q < LAST_SENSOR) begin
          sensor_d = sensor_q + 4'd1;
          pass_d   = '0;
          state_d  = ST_TRIGGER;
          tmr_d    = TRIG_LOAD;
        end else begin
          state_d = ST_DONE;
          if (best_q == INVALID_DIST) loc_d = NO_LOCATION;
          else begin
            // Sensors sit on 15-degree centres: angle code 2*i+1, low 4 bits.
            loc_d.angle    = 4'({best_idx_q, 1'b1});
            loc_d.distance = best_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sensor_q   <= '0;
      pass_q     <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      pv_q       <= '0;
      med_q      <= '0;
      best_q     <= INVALID_DIST;
      best_idx_q <= '0;
      loc_q      <= '0;
    end else begin
      state_q    <= state_d;
      sensor_q   <= sensor_d;
      pass_q     <= pass_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      pv_q       <= pv_d;
      med_q      <= med_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      loc_q      <= loc_d;
    end
  end

endmodule

// File: tb/tb_ultrasound_location_calculator.sv
// Directed sweeps of the rangefinder controller with a result scoreboard.
module tb_ultrasound_location_calculator;

  logic        clock = 1'b0;
  logic        reset;
  logic        calculate;
  logic [9:0]  ultrasound_signals;
  logic        done;
  logic [11:0] rover_location;
  logic [9:0]  ultrasound_commands;
  logic [9:0]  ultrasound_power;
  logic [3:0]  state;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];
  int tab[10][3];

  ultrasound_location_calculator dut (
    .clock               (clock),
    .reset               (reset),
    .calculate           (calculate),
    .ultrasound_signals  (ultrasound_signals),
    .done                (done),
    .rover_location      (rover_location),
    .ultrasound_commands (ultrasound_commands),
    .ultrasound_power    (ultrasound_power),
    .state               (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pass_val(input int len);
    int v;
    if (len == 0 || len >= 100) return 255;
    v = len / 2 + 5;
    return (v > 254) ? 254 : v;
  endfunction

  function automatic int median_of(input int a, input int b, input int c);
    int t;
    if (a > b) begin t = a; a = b; b = t; end
    if (b > c) begin t = b; b = c; c = t; end
    if (a > b) begin t = a; a = b; b = t; end
    return b;
  endfunction

  function automatic logic [11:0] expected_loc();
    int best = 255;
    int idx  = 0;
    int m;
    for (int i = 0; i < 10; i++) begin
      m = median_of(pass_val(tab[i][0]), pass_val(tab[i][1]), pass_val(tab[i][2]));
      if (m != 255 && m < best) begin best = m; idx = i; end
    end
    if (best == 255) return 12'hFFF;
    return {4'((2 * idx + 1) % 16), 8'(best)};
  endfunction

  task automatic clear_tab();
    for (int i = 0; i < 10; i++)
      for (int p = 0; p < 3; p++) tab[i][p] = 0;
  endtask

  task automatic set_sensor(input int s, input int l0, input int l1, input int l2);
    tab[s][0] = l0; tab[s][1] = l1; tab[s][2] = l2;
  endtask

  // One ping: check trigger pulse, drive echo (plus noise on a neighbour),
  // count power-low clocks until the controller reaches GAP.
  task automatic run_pass(input int s, input int len, input bit mid_calc);
    int  w;
    int  pw = 0;
    bit  at_gap = 0;
    logic [9:0] onehot;
    onehot = 10'b1 << s;
    for (int i = 0; i < 60 && ultrasound_commands == 0; i++) @(negedge clock);
    check("trig_seen", 32'(ultrasound_commands != 0), 1);
    check("trig_onehot", 32'(ultrasound_commands), 32'(onehot));
    w = 0;
    while (ultrasound_commands != 0 && w < 20) begin w++; @(negedge clock); end
    check("trig_width", w, 4);
    for (int k = 0; k < 500 && !at_gap; k++) begin
      if (state == 4'd5) at_gap = 1;
      else begin
        if (ultrasound_power[s] == 1'b0) pw++;
        ultrasound_signals = '0;
        ultrasound_signals[(s + 1) % 10] = 1'($urandom_range(0, 1));
        ultrasound_signals[s] = (len > 0 && k >= 2 && k < 2 + len);
        calculate = (mid_calc && k == 6);
        @(negedge clock);
      end
    end
    ultrasound_signals = '0;
    calculate = 1'b0;
    check("pass_reached_gap", 32'(at_gap), 1);
    check("power_low_clocks", pw, (len == 0 || len >= 100) ? 6 : 0);
  endtask

  task automatic run_sweep(input bit mid_calc);
    logic [11:0] e;
    exp_q.push_back(expected_loc());
    calculate = 1'b1;
    @(negedge clock);
    calculate = 1'b0;
    for (int s = 0; s < 10; s++)
      for (int p = 0; p < 3; p++)
        run_pass(s, tab[s][p], mid_calc && s == 3 && p == 0);
    for (int i = 0; i < 50 && !done; i++) @(negedge clock);
    check("done_seen", 32'(done), 1);
    check("done_state", 32'(state), 32'd10);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("location", 32'(rover_location), 32'(e));
      repeat (3) @(negedge clock);
      check("location_held", 32'(rover_location), 32'(e));
      check("done_held", 32'(done), 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    calculate = 1'b0;
    ultrasound_signals = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_state", 32'(state), 0);
    check("rst_done", 32'(done), 0);
    check("rst_location", 32'(rover_location), 0);
    check("rst_commands", 32'(ultrasound_commands), 0);
    check("rst_power", 32'(ultrasound_power), 32'h3FF);

    // Reference sweep: sensor 3 nearest.
    clear_tab();
    set_sensor(0, 40, 28, 45);
    set_sensor(1, 45, 45, 45);
    set_sensor(2, 45, 45, 45);
    set_sensor(3, 28, 28, 28);
    set_sensor(4, 101, 101, 101);
    set_sensor(5, 45, 45, 45);
    run_sweep(1'b0);
    check("ref_location_const", 32'(rover_location), 32'h713);

    // No echoes anywhere, calculate pulsed mid-sweep.
    clear_tab();
    run_sweep(1'b1);
    check("none_location_const", 32'(rover_location), 32'hFFF);

    // Median selection; two invalid passes make a sensor invalid.
    clear_tab();
    set_sensor(0, 40, 28, 45);
    set_sensor(1, 101, 101, 20);
    run_sweep(1'b0);
    check("median_location_const", 32'(rover_location), 32'h119);

    // Angle wraps to 4 bits; tie keeps the lower index.
    clear_tab();
    set_sensor(2, 45, 45, 45);
    set_sensor(7, 28, 28, 28);
    set_sensor(9, 28, 28, 28);
    run_sweep(1'b0);
    check("wrap_location_const", 32'(rover_location), 32'hF13);

    // Reset during MEASURE.
    calculate = 1'b1;
    @(negedge clock);
    calculate = 1'b0;
    for (int i = 0; i < 60 && ultrasound_commands == 0; i++) @(negedge clock);
    for (int i = 0; i < 20 && ultrasound_commands != 0; i++) @(negedge clock);
    ultrasound_signals[0] = 1'b1;
    for (int i = 0; i < 10 && state != 4'd3; i++) @(negedge clock);
    check("reached_measure", 32'(state), 3);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_commands", 32'(ultrasound_commands), 0);
    check("mid_rst_power", 32'(ultrasound_power), 32'h3FF);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_location", 32'(rover_location), 0);
    reset = 1'b0;
    ultrasound_signals = '0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
